// File: rtl/clock12_timekeeper_pkg.sv
// Shared 12-hour time constants and load-sanitising helpers used by the
// setter, the timekeeper and the alarm comparator.
package clock12_timekeeper_pkg;

    localparam logic [3:0] HOUR_MIN      = 4'd1;
    localparam logic [3:0] HOUR_MAX      = 4'd12;
    localparam logic [5:0] MIN_MAX       = 6'd59;
    localparam logic [5:0] SEC_MAX       = 6'd59;

    localparam logic       RESET_PM      = 1'b0;
    localparam logic [3:0] RESET_HOURS   = 4'd12;
    localparam logic [5:0] RESET_MINUTES = 6'd0;
    localparam logic [5:0] RESET_SECONDS = 6'd0;

    // Out-of-range hours collapse to 12 so the counter never leaves 1..12.
    function automatic logic [3:0] legal_hours(input logic [3:0] h);
        return (h < HOUR_MIN || h > HOUR_MAX) ? HOUR_MAX : h;
    endfunction

    function automatic logic [5:0] legal_minutes(input logic [5:0] m);
        return (m > MIN_MAX) ? 6'd0 : m;
    endfunction

endpackage

// File: rtl/clock12_timekeeper_sec_prescaler.sv
// Divides clk down to a one-cycle sec_en pulse every TICKS_PER_SEC cycles;
// hold freezes the phase and clear restarts it from zero.
module sec_prescaler #(
    parameter int  TICKS_PER_SEC = 50000000,
    localparam int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic clear,
    output logic sec_en
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               terminal;

    assign terminal = (cnt_q == PRESC_W'(TICKS_PER_SEC - 1));
    assign sec_en   = terminal && !hold && !clear;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock12_timekeeper.sv
// Running 12-hour time-of-day counter: loads from the setter, advances
// seconds/minutes/hours/AM-PM once per second and emits rollover strobes.
module clock12_timekeeper
    import clock12_timekeeper_pkg::*;
#(
    parameter int  TICKS_PER_SEC = 50000000,
    localparam int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       load,
    input  logic       load_pm,
    input  logic [3:0] load_hours,
    input  logic [5:0] load_minutes,
    output logic       isPM,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_tick
);

    logic       sec_en;
    logic       pm_q, pm_d;
    logic [3:0] hours_q, hours_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       sec_tick_q, sec_tick_d;
    logic       min_tick_q, min_tick_d;
    logic       hour_tick_q, hour_tick_d;

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .clear  (load),
        .sec_en (sec_en)
    );

    // Load wins over a coincident second; that second is simply dropped.
    always_comb begin
        pm_d        = pm_q;
        hours_d     = hours_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_tick_d  = 1'b0;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        if (load) begin
            pm_d    = load_pm;
            hours_d = legal_hours(load_hours);
            min_d   = legal_minutes(load_minutes);
            sec_d   = RESET_SECONDS;
        end else if (sec_en) begin
            sec_tick_d = 1'b1;
            if (sec_q == SEC_MAX) begin
                sec_d      = 6'd0;
                min_tick_d = 1'b1;
                if (min_q == MIN_MAX) begin
                    min_d       = 6'd0;
                    hour_tick_d = 1'b1;
                    // AM/PM flips on entering 12, not on leaving it.
                    if (hours_q == HOUR_MAX) begin
                        hours_d = HOUR_MIN;
                    end else begin
                        hours_d = hours_q + 4'd1;
                        if (hours_q == HOUR_MAX - 4'd1) begin
                            pm_d = ~pm_q;
                        end
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pm_q        <= RESET_PM;
            hours_q     <= RESET_HOURS;
            min_q       <= RESET_MINUTES;
            sec_q       <= RESET_SECONDS;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            hours_q     <= hours_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_tick_q  <= sec_tick_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
        end
    end

    assign isPM      = pm_q;
    assign hours     = hours_q;
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign sec_tick  = sec_tick_q;
    assign min_tick  = min_tick_q;
    assign hour_tick = hour_tick_q;

endmodule

// File: tb/tb_clock12_timekeeper.sv
// Self-checking bench for clock12_timekeeper: a seconds-of-day reference model
// compared every cycle, plus directed rollover/load/hold/reset scenarios.
module tb_clock12_timekeeper;

    localparam int TPS = 4;
    localparam int DAY = 86400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hold = 1'b0;
    logic       load = 1'b0;
    logic       load_pm = 1'b0;
    logic [3:0] load_hours = 4'd0;
    logic [5:0] load_minutes = 6'd0;
    logic       isPM;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;

    int  errors = 0;
    int  checks = 0;
    bit  checkEn = 1'b0;

    int  mdlTod;
    int  mdlPhase;
    bit  mdlSecT, mdlMinT, mdlHourT;

    clock12_timekeeper #(
        .TICKS_PER_SEC(TPS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .load         (load),
        .load_pm      (load_pm),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .isPM         (isPM),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .sec_tick     (sec_tick),
        .min_tick     (min_tick),
        .hour_tick    (hour_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Time of day is modelled as seconds since midnight on a 24-hour dial.
    function automatic int mdlHours(input int tod);
        int h12;
        h12 = (tod / 3600) % 12;
        return (h12 == 0) ? 12 : h12;
    endfunction

    function automatic int mdlPm(input int tod);
        return (tod >= DAY / 2) ? 1 : 0;
    endfunction

    function automatic int loadTod(input bit pm, input int h, input int m);
        int hh, mm;
        hh = (h == 0 || h > 12) ? 12 : h;
        mm = (m > 59) ? 0 : m;
        return ((hh % 12) + (pm ? 12 : 0)) * 3600 + mm * 60;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdlTod   <= 0;
            mdlPhase <= 0;
            mdlSecT  <= 1'b0;
            mdlMinT  <= 1'b0;
            mdlHourT <= 1'b0;
        end else begin
            mdlSecT  <= 1'b0;
            mdlMinT  <= 1'b0;
            mdlHourT <= 1'b0;
            if (load) begin
                mdlTod   <= loadTod(load_pm, int'(load_hours), int'(load_minutes));
                mdlPhase <= 0;
            end else if (!hold) begin
                if (mdlPhase == TPS - 1) begin
                    mdlPhase <= 0;
                    mdlTod   <= (mdlTod + 1) % DAY;
                    mdlSecT  <= 1'b1;
                    mdlMinT  <= ((mdlTod + 1) % 60 == 0);
                    mdlHourT <= ((mdlTod + 1) % 3600 == 0);
                end else begin
                    mdlPhase <= mdlPhase + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("isPM",      int'(isPM),      mdlPm(mdlTod));
            checkOutput("hours",     int'(hours),     mdlHours(mdlTod));
            checkOutput("minutes",   int'(minutes),   (mdlTod / 60) % 60);
            checkOutput("seconds",   int'(seconds),   mdlTod % 60);
            checkOutput("sec_tick",  int'(sec_tick),  int'(mdlSecT));
            checkOutput("min_tick",  int'(min_tick),  int'(mdlMinT));
            checkOutput("hour_tick", int'(hour_tick), int'(mdlHourT));
        end
    end

    task automatic applyStimulus(input bit h, input bit ld, input bit pm, input int hr, input int mn);
        hold         = h;
        load         = ld;
        load_pm      = pm;
        load_hours   = 4'(hr);
        load_minutes = 6'(mn);
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic checkTime(input string tag, input int pm, input int h, input int m, input int s);
        checkOutput({tag, " isPM"},    int'(isPM),    pm);
        checkOutput({tag, " hours"},   int'(hours),   h);
        checkOutput({tag, " minutes"}, int'(minutes), m);
        checkOutput({tag, " seconds"}, int'(seconds), s);
    endtask

    task automatic checkTicks(input string tag, input int st, input int mt, input int ht);
        checkOutput({tag, " sec_tick"},  int'(sec_tick),  st);
        checkOutput({tag, " min_tick"},  int'(min_tick),  mt);
        checkOutput({tag, " hour_tick"}, int'(hour_tick), ht);
    endtask

    initial begin
        int tickCount;
        int firstTick;
        int holdTod;

        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkTime("reset", 0, 12, 0, 0);
        checkTicks("reset", 0, 0, 0);
        checkEn = 1'b1;
        reset   = 1'b1;

        tickCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
            if (sec_tick) tickCount++;
        end
        checkOutput("count sec_tick pulses", tickCount, 2);
        checkTime("count 8 cycles", 0, 12, 0, 2);

        applyStimulus(1'b0, 1'b1, 1'b0, 11, 59);
        runCycles(240);
        checkTime("11:59 AM roll", 1, 12, 0, 0);
        checkTicks("11:59 AM roll", 1, 1, 1);

        applyStimulus(1'b0, 1'b1, 1'b1, 12, 59);
        runCycles(240);
        checkTime("12:59 PM roll", 1, 1, 0, 0);
        checkTicks("12:59 PM roll", 1, 1, 1);

        applyStimulus(1'b0, 1'b1, 1'b1, 11, 59);
        runCycles(240);
        checkTime("11:59 PM roll", 0, 12, 0, 0);
        checkTicks("11:59 PM roll", 1, 1, 1);

        runCycles(2);
        for (int i = 0; i < 8 && mdlPhase != TPS - 1; i++) runCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 5, 30);
        load = 1'b0;
        checkTime("load at terminal", 0, 5, 30, 0);
        checkTicks("load at terminal", 0, 0, 0);
        firstTick = 0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
            if (sec_tick && firstTick == 0) firstTick = i;
        end
        checkOutput("first tick after load", firstTick, 4);

        runCycles(6);
        holdTod   = mdlTod;
        tickCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
            if (sec_tick) tickCount++;
        end
        checkOutput("hold ticks", tickCount, 0);
        checkOutput("hold seconds frozen", int'(seconds), holdTod % 60);
        checkOutput("hold minutes frozen", int'(minutes), (holdTod / 60) % 60);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 63);
        checkTime("illegal load in hold", 1, 12, 0, 0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        runCycles(10);

        applyStimulus(1'b0, 1'b1, 1'b1, 3, 17);
        runCycles(168);
        checkTime("before async reset", 1, 3, 17, 42);
        #2 reset = 1'b0;
        #1;
        checkTime("async reset", 0, 12, 0, 0);
        checkTicks("async reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        runCycles(8);
        checkOutput("restart seconds", int'(seconds), 2);

        for (int i = 0; i < 3000; i++) begin
            bit rHold, rLoad, rPm;
            int rH, rM;
            rHold = ($urandom_range(0, 7) == 0);
            rLoad = ($urandom_range(0, 299) == 0);
            rPm   = ($urandom_range(0, 1) == 1);
            rH    = $urandom_range(0, 15);
            rM    = ($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 63);
            applyStimulus(rHold, rLoad, rPm, rH, rM);
        end

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock12_timekeeper.md
Name: clock12_timekeeper

Overview:
Running 12-hour time-of-day counter that sits directly downstream of the 12-hour setting stage. It loads AM/PM, hour and minute on the setter's one-cycle load pulse, then advances seconds, minutes, hours and AM/PM from an internal clk-cycle prescaler. It drives the display formatter and the alarm comparator with current time and one-cycle rollover strobes.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 2
PRESC_W, $clog2(TICKS_PER_SEC), prescaler counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, release is synchronous to clk
hold  input  1  high freezes prescaler and all time counters; load still honoured
load  input  1  one-cycle load strobe from setter (its propagate output)
load_pm  input  1  AM/PM value to load; 1 = PM
load_hours  input  4  hour value to load, legal 1..12
load_minutes  input  6  minute value to load, legal 0..59
isPM  output  1  current AM/PM
hours  output  4  current hour, 1..12
minutes  output  6  current minute, 0..59
seconds  output  6  current second, 0..59
sec_tick  output  1  one-cycle strobe on every seconds advance
min_tick  output  1  one-cycle strobe when minutes advance (seconds 59->0)
hour_tick  output  1  one-cycle strobe when hours advance (minutes 59->0 with seconds 59->0)

Behaviour:
- Reset (reset low): isPM=0, hours=12, minutes=0, seconds=0, prescaler=0, all strobes 0. This matches the setter's reset time of 12:00 AM.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while hold=0.
  - Terminal count produces an internal sec_en in that cycle and wraps the prescaler to 0.
  - hold=1 freezes the prescaler value.
- Time update on sec_en (registered, visible the cycle after terminal count):
  - seconds+1; at 59, seconds goes to 0 and minutes advance.
  - Minutes at 59 go to 0 and hours advance.
  - Hours 11->12 toggles isPM. Hours 12->1 does not toggle. All other hours increment.
  - So 11:59:59 AM -> 12:00:00 PM, 11:59:59 PM -> 12:00:00 AM, and 12:59:59 -> 1:00:00 with isPM unchanged.
- Strobes:
  - Registered; high exactly in the cycle the new time value first appears.
  - hour_tick implies min_tick, and min_tick implies sec_tick.
- Load:
  - When load=1, next cycle isPM=load_pm, hours=load_hours, minutes=load_minutes, seconds=0, prescaler=0, all strobes 0.
  - load has priority over a coincident sec_en; that second is dropped.
  - load is honoured regardless of hold.
- Illegal load values:
  - load_hours of 0 or >12 loads 12.
  - load_minutes >59 loads 0.
  - load_pm is taken as-is.
- hold=1 with no load: all outputs keep their value and strobes are 0.
- Reset asserted mid-count or mid-load returns everything to the reset state with no strobe.
- All arithmetic is unsigned at each field's own width. Counters never hold an out-of-range value.

Decomposition:
- Shared package: constants HOUR_MIN=1, HOUR_MAX=12, MIN_MAX=59, SEC_MAX=59, plus the reset time (12, 0, AM). The setter and the alarm comparator use the same constants.
- One natural sub-module: sec_prescaler. It takes clk, reset, hold and clear (driven by load), is parameterised by TICKS_PER_SEC, and outputs sec_en.
- The hour/minute/second cascade stays in the top module.

Test Plan:
- TICKS_PER_SEC=4, reset released, hold=0, 8 clk cycles -> seconds 0->1->2; sec_tick pulses once per 4 cycles; time reads 12:00:02 AM.
- load with load_pm=0, load_hours=11, load_minutes=59; run 60 s -> at 59 s the next tick gives 12:00:00 PM (isPM=1), with sec_tick, min_tick and hour_tick all high in one cycle.
- load PM 12:59; run 60 s -> 1:00:00, isPM stays 1, hour_tick=1. Separately, load PM 11:59 and run 60 s -> 12:00:00 AM, isPM=0.
- load asserted in the same cycle as prescaler terminal count with load_hours=5, load_minutes=30 -> next cycle 5:30:00, no strobes, prescaler restarts from 0 (first sec_tick 4 cycles later).
- hold=1 for 20 cycles mid-count -> outputs and prescaler frozen, no strobes. hold=0 resumes from the same prescaler phase. load during hold with load_hours=0, load_minutes=63 -> loads 12:00:00.
- Drive reset low asynchronously mid-cycle at 3:17:42 PM -> outputs immediately 12:00:00 AM, strobes 0; counting restarts after release.
